trng_word_packer: RTL and testbench
===================================

TRNG_WORD_PACKER -- requirements
Module: trng_word_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning output word width in bits (legal range 8..64).
REQ-002 SHALL have parameter RCT_CUTOFF, default 32, meaning the repetition-count run length that declares failure (legal range 2..255).
REQ-003 SHALL have parameter APT_WINDOW, default 512, meaning the adaptive-proportion window length in bits.
REQ-004 SHALL have parameter APT_CUTOFF, default 410, meaning the adaptive-proportion match count that declares failure.
REQ-005 SHALL have these ports, in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  packer run enable.
- bit_in  input  1  debiased random bit from the upstream extractor.
- bit_valid  input  1  bit_in is valid this cycle; no backpressure upstream.
- word_out  output  WORD_W  packed random word.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  consumer accepts word_out.
- health_fail  output  1  sticky health-test failure.
- overrun  output  1  sticky flag: an accepted bit was dropped.
- clear_fail  input  1  clears health_fail and overrun.

Function
REQ-006 SHALL accept a bit on a cycle with enable=1, bit_valid=1 and state FILL.
REQ-007 SHALL pack accepted bits LSB-first: bit k of the word is the k-th accepted bit.
REQ-008 SHALL use these states: IDLE (enable=0), FILL (packing), FAIL (health test tripped).
- Transitions: IDLE->FILL when enable=1; FILL->IDLE when enable=0; FILL->FAIL on a health trip; FAIL->IDLE on clear_fail=1.
REQ-009 SHALL clear the shifter, bit counter and health counters on every entry to IDLE or FAIL.
REQ-010 SHALL transfer the shifter to the output register on the cycle after the WORD_W-th bit is accepted, if the output register is empty or is accepted that same cycle; word_valid SHALL rise on that same cycle.
REQ-011 SHALL hold word_out and word_valid stable until word_ready=1; a transfer SHALL complete on any cycle with word_valid and word_ready both 1.
REQ-012 SHALL keep word_valid at 1 with no bubble when a full shifter and a completing transfer coincide.
REQ-013 SHALL, when the shifter is full and the output register is occupied, drop further accepted bits and set overrun; the full shifter SHALL remain held.
REQ-014 SHALL run a repetition count test on every accepted bit:
- The run counter counts consecutive equal bits and saturates at RCT_CUTOFF.
- A run reaching RCT_CUTOFF SHALL set health_fail and enter FAIL.
- The bit that trips the test SHALL not be packed.
REQ-015 SHALL, on entry to FAIL, discard the partial shifter and clear word_valid, even without a handshake; failed-window data SHALL never be delivered.
REQ-016 SHALL ignore bit_valid in IDLE and FAIL.
REQ-017 SHALL, on clear_fail=1, clear health_fail and overrun in any state; clear_fail SHALL take priority over a trip in the same cycle.
REQ-018 SHALL, when enable falls, not discard a word already in the output register; the pending handshake SHALL still complete.

Reset
REQ-019 SHALL, while rst=0, force state IDLE, word_out=0, word_valid=0, health_fail=0, overrun=0, and clear all counters, regardless of clk.
REQ-020 SHALL, when reset asserts mid-word or mid-handshake, drop all data; there is no recovery of partial state.

Configuration
REQ-021 SHALL, with TRNG_APT_EN defined, add the adaptive proportion test:
- The first accepted bit of each APT_WINDOW-bit window is the reference.
- Matches of the reference reaching APT_CUTOFF within the window SHALL trip FAIL, as in REQ-014.
REQ-022 SHALL, without TRNG_APT_EN, omit all APT logic; APT_WINDOW and APT_CUTOFF SHALL have no effect.

Structure
REQ-023 SHALL take the state encoding and the default constants (RCT_CUTOFF, APT_WINDOW, APT_CUTOFF) from shared package trng_pkg.
REQ-024 SHALL implement the health tests in one sub-module, trng_health_test, which takes the accepted bit and strobe and returns a one-cycle trip pulse.

Verification
REQ-025 SHALL cover:
- Word packing: WORD_W=32, 32 alternating bits starting with 1 -> word_out=32'h5555_5555 with word_valid=1 one cycle after the 32nd bit.
- Backpressure: word_ready=0 while 64 more bits arrive -> the second word is held, later bits are dropped, overrun=1, and the first word is unchanged.
- RCT trip: RCT_CUTOFF=32, 32 consecutive 0s -> health_fail=1, word_valid=0, further bits ignored; clear_fail -> health_fail=0 and state IDLE.
- Zero-bubble handshake: word_ready=1 continuously, bit_valid every cycle -> a new word every 32 cycles and no overrun.
- Async reset: rst=0 mid-word, with no clock edge -> all outputs 0 immediately.
- With TRNG_APT_EN: a 512-bit window containing 410 ones and no run of 32 -> health_fail=1.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared FSM encoding and default health-test constants for the TRNG word packer.
package trng_pkg;

   localparam int DEF_RCT_CUTOFF = 32;
   localparam int DEF_APT_WINDOW = 512;
   localparam int DEF_APT_CUTOFF = 410;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_FAIL = 2'd2
   } state_e;

endpackage

// File: rtl/trng_health_test.sv
// Repetition-count test, plus the adaptive-proportion test when TRNG_APT_EN is defined.
// trip is combinational on the offending strobe so the packer can refuse that very bit.
module trng_health_test
   import trng_pkg::*;
#(
   parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW = DEF_APT_WINDOW,
   parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic strobe,
   input  logic bit_in,
   output logic trip
);

   localparam logic [7:0] RCT_LIM = 8'(RCT_CUTOFF);

   logic       last_q, last_d;
   logic [7:0] run_q, run_d, run_next;
   logic       rct_trip;

   always_comb begin
      run_next = 8'd1;
      if (run_q != 8'd0 && bit_in == last_q)
         run_next = (run_q < RCT_LIM) ? run_q + 8'd1 : RCT_LIM;
      rct_trip = strobe && (run_next == RCT_LIM);
      last_d   = last_q;
      run_d    = run_q;
      if (clear) begin
         last_d = 1'b0;
         run_d  = 8'd0;
      end else if (strobe) begin
         last_d = bit_in;
         run_d  = run_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b0;
         run_q  <= 8'd0;
      end else begin
         last_q <= last_d;
         run_q  <= run_d;
      end
   end

`ifdef TRNG_APT_EN
   localparam int            AW       = $clog2(APT_WINDOW + 1);
   localparam logic [AW-1:0] WIN_LAST = AW'(APT_WINDOW - 1);
   localparam logic [AW-1:0] APT_LIM  = AW'(APT_CUTOFF);

   logic [AW-1:0] win_q, win_d, match_q, match_d, match_next;
   logic          ref_q, ref_d, apt_trip;

   // The first bit of each window is the reference and counts as its own first match.
   always_comb begin
      match_next = AW'(1);
      if (win_q != '0)
         match_next = match_q + ((bit_in == ref_q) ? AW'(1) : AW'(0));
      apt_trip = strobe && (match_next == APT_LIM);
      win_d    = win_q;
      match_d  = match_q;
      ref_d    = ref_q;
      if (clear) begin
         win_d   = '0;
         match_d = '0;
         ref_d   = 1'b0;
      end else if (strobe) begin
         if (win_q == '0)
            ref_d = bit_in;
         match_d = match_next;
         win_d   = (win_q == WIN_LAST) ? '0 : win_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_q   <= '0;
         match_q <= '0;
         ref_q   <= 1'b0;
      end else begin
         win_q   <= win_d;
         match_q <= match_d;
         ref_q   <= ref_d;
      end
   end

   assign trip = rct_trip || apt_trip;
`else
   // APT parameters have no effect when the adaptive-proportion test is compiled out.
   localparam int APT_PARAMS_UNUSED = APT_WINDOW + APT_CUTOFF;

   assign trip = rct_trip;
`endif

endmodule

// File: rtl/trng_word_packer.sv
// Packs health-tested random bits LSB-first into WORD_W-bit words with a valid/ready output.
// Define TRNG_APT_EN to add the adaptive-proportion test to the health checks.
module trng_word_packer
   import trng_pkg::*;
#(
   parameter int WORD_W     = 32,
   parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW = DEF_APT_WINDOW,
   parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              health_fail,
   output logic              overrun,
   input  logic              clear_fail
);

   localparam int            CW       = $clog2(WORD_W + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WORD_W);
   localparam logic [CW-1:0] CNT_LAST = CW'(WORD_W - 1);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] shift_q, shift_d, out_q, out_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              valid_q, valid_d, fail_q, fail_d, ovr_q, ovr_d;
   logic              accept, trip, trip_eff, out_free, full;

   assign accept   = enable && bit_valid && (state_q == ST_FILL);
   assign trip_eff = trip && !clear_fail;
   assign out_free = !valid_q || word_ready;
   assign full     = (cnt_q == CNT_FULL);

   trng_health_test #(
      .RCT_CUTOFF(RCT_CUTOFF),
      .APT_WINDOW(APT_WINDOW),
      .APT_CUTOFF(APT_CUTOFF)
   ) u_health (
      .clk    (clk),
      .rst    (rst),
      .clear  (state_q != ST_FILL),
      .strobe (accept),
      .bit_in (bit_in),
      .trip   (trip)
   );

   // A held full shifter moves out as soon as the slot frees, so the new bit can start the next word.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      valid_d = valid_q;
      fail_d  = fail_q;
      ovr_d   = ovr_q;
      if (valid_q && word_ready)
         valid_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable)
               state_d = ST_FILL;
         end
         ST_FILL: begin
            if (trip_eff) begin
               state_d = ST_FAIL;
               fail_d  = 1'b1;
               valid_d = 1'b0;
               shift_d = '0;
               cnt_d   = '0;
            end else if (!enable) begin
               state_d = ST_IDLE;
               shift_d = '0;
               cnt_d   = '0;
            end else begin
               if (full && out_free) begin
                  out_d   = shift_q;
                  valid_d = 1'b1;
                  shift_d = '0;
                  cnt_d   = '0;
               end
               if (accept) begin
                  if (full && !out_free) begin
                     ovr_d = 1'b1;
                  end else if (cnt_d == CNT_LAST && out_free) begin
                     out_d   = {bit_in, shift_d[WORD_W-1:1]};
                     valid_d = 1'b1;
                     shift_d = '0;
                     cnt_d   = '0;
                  end else begin
                     shift_d = {bit_in, shift_d[WORD_W-1:1]};
                     cnt_d   = cnt_d + CW'(1);
                  end
               end
            end
         end
         ST_FAIL: begin
            if (clear_fail)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_fail) begin
         fail_d = 1'b0;
         ovr_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         fail_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         fail_q  <= fail_d;
         ovr_q   <= ovr_d;
      end
   end

   assign word_out    = out_q;
   assign word_valid  = valid_q;
   assign health_fail = fail_q;
   assign overrun     = ovr_q;

endmodule

// File: tb/tb_trng_word_packer.sv
// Directed bench for trng_word_packer: delivered words are checked against a scoreboard queue.
module tb_trng_word_packer;
   import trng_pkg::*;

   localparam int WORD_W = 32;

   logic              clk, rst, enable, bit_in, bit_valid, word_ready, clear_fail;
   logic [WORD_W-1:0] word_out;
   logic              word_valid, health_fail, overrun;

   logic [WORD_W-1:0] sbQueue[$];
   int                nAsserts;
   int                nFails;

   trng_word_packer #(
      .WORD_W    (WORD_W),
      .RCT_CUTOFF(32),
      .APT_WINDOW(512),
      .APT_CUTOFF(410)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .health_fail(health_fail),
      .overrun    (overrun),
      .clear_fail (clear_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nAsserts++;
      assert (observed === expected)
      else begin
         nFails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Every completed handshake must match the oldest word the bench expects to be delivered.
   task automatic sampleHandshake();
      logic [WORD_W-1:0] exp;
      if (word_valid && word_ready) begin
         nAsserts++;
         assert (sbQueue.size() != 0)
         else begin
            nFails++;
            $error("[TB] FAIL unexpected_word observed=%0h expected=no_word", word_out);
         end
         if (sbQueue.size() != 0) begin
            exp = sbQueue.pop_front();
            checkOutput("word_data", word_out, exp);
         end
      end
   endtask

   task automatic applyStimulus(input logic b, input logic v);
      bit_in    = b;
      bit_valid = v;
      @(negedge clk);
      sampleHandshake();
      @(posedge clk);
      #1;
   endtask

   task automatic sendWord(input logic [WORD_W-1:0] w);
      for (int i = 0; i < WORD_W; i++)
         applyStimulus(w[i], 1'b1);
   endtask

   task automatic zeroBubbleWord(input logic [WORD_W-1:0] w);
      sbQueue.push_back(w);
      sendWord(w);
      checkOutput("zero_bubble_valid", word_valid, 1);
      checkOutput("zero_bubble_data", word_out, w);
   endtask

   initial begin
      nAsserts   = 0;
      nFails     = 0;
      rst        = 1'b1;
      enable     = 1'b0;
      bit_in     = 1'b0;
      bit_valid  = 1'b0;
      word_ready = 1'b0;
      clear_fail = 1'b0;
      #1 rst = 1'b0;
      #2;
      checkOutput("reset_word_out", word_out, 0);
      checkOutput("reset_word_valid", word_valid, 0);
      checkOutput("reset_health_fail", health_fail, 0);
      checkOutput("reset_overrun", overrun, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      $display("[TB] word packing");
      enable = 1'b1;
      applyStimulus(1'b0, 1'b0);
      for (int k = 0; k < WORD_W - 1; k++)
         applyStimulus((k % 2) == 0, 1'b1);
      checkOutput("pack_no_early_valid", word_valid, 0);
      applyStimulus(1'b0, 1'b1);
      sbQueue.push_back(32'h5555_5555);
      checkOutput("pack_valid", word_valid, 1);
      checkOutput("pack_data", word_out, 32'h5555_5555);

      $display("[TB] backpressure");
      sendWord(32'hA5C3_0F96);
      sbQueue.push_back(32'hA5C3_0F96);
      checkOutput("bp_no_overrun_yet", overrun, 0);
      sendWord(32'h1234_5678);
      checkOutput("bp_overrun", overrun, 1);
      checkOutput("bp_held_valid", word_valid, 1);
      checkOutput("bp_held_data", word_out, 32'h5555_5555);
      word_ready = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkOutput("bp_no_bubble_valid", word_valid, 1);
      checkOutput("bp_second_word", word_out, 32'hA5C3_0F96);
      applyStimulus(1'b0, 1'b0);
      checkOutput("bp_drained", word_valid, 0);
      clear_fail = 1'b1;
      applyStimulus(1'b0, 1'b0);
      clear_fail = 1'b0;
      checkOutput("bp_overrun_cleared", overrun, 0);

      $display("[TB] zero-bubble stream");
      zeroBubbleWord(32'hDEAD_BEEF);
      zeroBubbleWord(32'h0123_4567);
      zeroBubbleWord(32'hCAFE_F00D);
      applyStimulus(1'b0, 1'b0);
      checkOutput("zb_no_overrun", overrun, 0);

      $display("[TB] repetition count trip");
      word_ready = 1'b0;
      for (int k = 0; k < 9; k++)
         applyStimulus((k % 2) == 0, 1'b1);
      for (int k = 0; k < 23; k++)
         applyStimulus(1'b0, 1'b1);
      checkOutput("rct_pending_valid", word_valid, 1);
      checkOutput("rct_pending_data", word_out, 32'h0000_0155);
      for (int k = 0; k < 8; k++)
         applyStimulus(1'b0, 1'b1);
      checkOutput("rct_run31_no_trip", health_fail, 0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("rct_trip", health_fail, 1);
      checkOutput("rct_valid_dropped", word_valid, 0);
      word_ready = 1'b1;
      for (int k = 0; k < 40; k++)
         applyStimulus(k[2], 1'b1);
      checkOutput("rct_fail_sticky", health_fail, 1);
      checkOutput("rct_fail_no_output", word_valid, 0);
      clear_fail = 1'b1;
      applyStimulus(1'b0, 1'b0);
      clear_fail = 1'b0;
      checkOutput("rct_cleared", health_fail, 0);
      checkOutput("rct_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
      applyStimulus(1'b0, 1'b0);
      sbQueue.push_back(32'h3C3C_5AA5);
      sendWord(32'h3C3C_5AA5);
      applyStimulus(1'b0, 1'b0);

      $display("[TB] asynchronous reset");
      word_ready = 1'b0;
      sendWord(32'h0F0F_F0F0);
      sendWord(32'h7777_1111);
      for (int k = 0; k < 8; k++)
         applyStimulus(k[0], 1'b1);
      checkOutput("ar_overrun_before", overrun, 1);
      #2 rst = 1'b0;
      #1;
      checkOutput("ar_word_out", word_out, 0);
      checkOutput("ar_word_valid", word_valid, 0);
      checkOutput("ar_overrun", overrun, 0);
      checkOutput("ar_health_fail", health_fail, 0);
      checkOutput("ar_state_idle", 64'(dut.state_q), 64'(ST_IDLE));
      @(posedge clk);
      #1 rst = 1'b1;
      word_ready = 1'b1;
      applyStimulus(1'b0, 1'b0);
      sbQueue.push_back(32'h8421_BDE7);
      sendWord(32'h8421_BDE7);
      applyStimulus(1'b0, 1'b0);

`ifdef TRNG_APT_EN
      $display("[TB] adaptive proportion trip");
      begin
         logic [WORD_W-1:0] w;
         logic              b;
         w      = '0;
         enable = 1'b0;
         applyStimulus(1'b0, 1'b0);
         enable = 1'b1;
         applyStimulus(1'b0, 1'b0);
         for (int i = 0; i < 512; i++) begin
            b = ((i % 5) != 4);
            w[i % WORD_W] = b;
            if (i == 511)
               checkOutput("apt_409_no_trip", health_fail, 0);
            applyStimulus(b, 1'b1);
            if ((i % WORD_W) == WORD_W - 1 && i != 511)
               sbQueue.push_back(w);
         end
         checkOutput("apt_trip", health_fail, 1);
         checkOutput("apt_valid_dropped", word_valid, 0);
         clear_fail = 1'b1;
         applyStimulus(1'b0, 1'b0);
         clear_fail = 1'b0;
      end
`endif

      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("scoreboard_empty", sbQueue.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
